// File: rtl/lamp_pwm_controller.sv
// Multi-channel lamp PWM driver with off/dim/full/blink levels, ramped steady changes
// and an attention flash burst on each new brake request.
`timescale 1ns/1ps

module lamp_pwm_controller #(
   parameter int CHANNELS    = 4,
   parameter int PWM_BITS    = 10,
   parameter int PWM_DIV     = 1,
   parameter int DIM_LEVEL   = 31,
   parameter int RAMP_STEP   = 32,
   parameter int BLINK_HALF  = 16_666_667,
   parameter int FLASH_HALF  = 2_500_000,
   parameter int FLASH_COUNT = 3
) (
   input  logic                c50M,
   input  logic                reset,
   input  logic [CHANNELS-1:0] onReq,
   input  logic [CHANNELS-1:0] dimReq,
   input  logic [CHANNELS-1:0] blinkReq,
   input  logic [CHANNELS-1:0] flashEn,
   output logic [CHANNELS-1:0] lampPWM,
   output logic                blinkPhase
);

   localparam int PRE_W   = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
   localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam int TIMER_W = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
   localparam int PULSE_W = $clog2(FLASH_COUNT + 1);
   localparam int MAX_INT = (1 << PWM_BITS) - 1;
   localparam int STEP_CLAMP = (RAMP_STEP > MAX_INT) ? MAX_INT : RAMP_STEP;

   localparam logic [PWM_BITS-1:0] DUTY_MAX   = '1;
   localparam logic [PWM_BITS-1:0] DIM_DUTY   = PWM_BITS'(DIM_LEVEL);
   localparam logic [PWM_BITS-1:0] STEP       = PWM_BITS'(STEP_CLAMP);
   localparam logic [PRE_W-1:0]    PRE_LAST   = PRE_W'(PWM_DIV - 1);
   localparam logic [BLINK_W-1:0]  BLINK_LAST = BLINK_W'(BLINK_HALF - 1);
   localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(FLASH_HALF - 1);
   localparam logic [PULSE_W-1:0]  PULSE_LAST = PULSE_W'(FLASH_COUNT);
   localparam logic [PULSE_W-1:0]  PULSE_ONE  = PULSE_W'(1);
   localparam bit                  RAMP_OFF   = (RAMP_STEP == 0);

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_FLASH_ON  = 2'd1;
   localparam logic [1:0] ST_FLASH_OFF = 2'd2;
   localparam logic [1:0] ST_STEADY    = 2'd3;

   logic [PRE_W-1:0]                    presc_q, presc_d;
   logic [PWM_BITS-1:0]                 pwm_count_q, pwm_count_d;
   logic [BLINK_W-1:0]                  blink_cnt_q, blink_cnt_d;
   logic                                blink_phase_q, blink_phase_d;
   logic [CHANNELS-1:0]                 on_prev_q, on_prev_d;
   logic [CHANNELS-1:0][1:0]            state_q, state_d;
   logic [CHANNELS-1:0][TIMER_W-1:0]    timer_q, timer_d;
   logic [CHANNELS-1:0][PULSE_W-1:0]    pulse_q, pulse_d;
   logic [CHANNELS-1:0][PWM_BITS-1:0]   duty_q, duty_d;
   logic [CHANNELS-1:0][PWM_BITS-1:0]   target;
   logic [CHANNELS-1:0]                 immediate;
   logic [CHANNELS-1:0]                 lamp_q, lamp_d;
   logic                                presc_wrap;
   logic                                pwm_wrap;

   always_comb begin
      presc_wrap    = (presc_q == PRE_LAST);
      presc_d       = presc_wrap ? '0 : presc_q + 1'b1;
      pwm_count_d   = presc_wrap ? pwm_count_q + 1'b1 : pwm_count_q;
      pwm_wrap      = presc_wrap && (pwm_count_q == DUTY_MAX);
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
      // Idle blink timebase parks lit so every blink sequence starts with the lamp on.
      if (blinkReq == '0) begin
         blink_cnt_d   = '0;
         blink_phase_d = 1'b1;
      end else if (blink_cnt_q == BLINK_LAST) begin
         blink_cnt_d   = '0;
         blink_phase_d = ~blink_phase_q;
      end else begin
         blink_cnt_d   = blink_cnt_q + 1'b1;
      end
   end

   always_comb begin
      on_prev_d = onReq;
      state_d   = state_q;
      timer_d   = timer_q;
      pulse_d   = pulse_q;
      for (int i = 0; i < CHANNELS; i++) begin
         if (!onReq[i]) begin
            state_d[i] = ST_IDLE;
            timer_d[i] = '0;
            pulse_d[i] = '0;
         end else begin
            case (state_q[i])
               ST_IDLE: begin
                  if (!on_prev_q[i]) begin
                     if (flashEn[i]) begin
                        state_d[i] = ST_FLASH_ON;
                        pulse_d[i] = PULSE_ONE;
                        timer_d[i] = '0;
                     end else begin
                        state_d[i] = ST_STEADY;
                     end
                  end
               end
               ST_FLASH_ON: begin
                  if (timer_q[i] == TIMER_LAST) begin
                     state_d[i] = ST_FLASH_OFF;
                     timer_d[i] = '0;
                  end else begin
                     timer_d[i] = timer_q[i] + 1'b1;
                  end
               end
               ST_FLASH_OFF: begin
                  if (timer_q[i] == TIMER_LAST) begin
                     timer_d[i] = '0;
                     if (pulse_q[i] < PULSE_LAST) begin
                        state_d[i] = ST_FLASH_ON;
                        pulse_d[i] = pulse_q[i] + 1'b1;
                     end else begin
                        state_d[i] = ST_STEADY;
                     end
                  end else begin
                     timer_d[i] = timer_q[i] + 1'b1;
                  end
               end
               default: state_d[i] = ST_STEADY;
            endcase
         end
      end
   end

   // Duty only moves at the PWM roll-over so a period is never cut short mid-pulse.
   always_comb begin
      duty_d = duty_q;
      lamp_d = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         immediate[i] = 1'b1;
         if (blinkReq[i])                        target[i] = blink_phase_q ? DUTY_MAX : '0;
         else if (state_q[i] == ST_FLASH_ON)     target[i] = DUTY_MAX;
         else if (state_q[i] == ST_FLASH_OFF)    target[i] = '0;
         else begin
            immediate[i] = RAMP_OFF;
            if (state_q[i] == ST_STEADY)         target[i] = DUTY_MAX;
            else if (dimReq[i])                  target[i] = DIM_DUTY;
            else                                 target[i] = '0;
         end
         if (pwm_wrap) begin
            if (immediate[i])
               duty_d[i] = target[i];
            else if (target[i] > duty_q[i])
               duty_d[i] = (target[i] - duty_q[i] > STEP) ? duty_q[i] + STEP : target[i];
            else
               duty_d[i] = (duty_q[i] - target[i] > STEP) ? duty_q[i] - STEP : target[i];
         end
         if (duty_q[i] == '0)             lamp_d[i] = 1'b0;
         else if (duty_q[i] == DUTY_MAX)  lamp_d[i] = 1'b1;
         else                             lamp_d[i] = (pwm_count_q < duty_q[i]);
      end
   end

   always_ff @(posedge c50M or posedge reset) begin
      if (reset) begin
         presc_q       <= '0;
         pwm_count_q   <= '0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b1;
         on_prev_q     <= '0;
         state_q       <= {CHANNELS{ST_IDLE}};
         timer_q       <= '0;
         pulse_q       <= '0;
         duty_q        <= '0;
         lamp_q        <= '0;
      end else begin
         presc_q       <= presc_d;
         pwm_count_q   <= pwm_count_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         on_prev_q     <= on_prev_d;
         state_q       <= state_d;
         timer_q       <= timer_d;
         pulse_q       <= pulse_d;
         duty_q        <= duty_d;
         lamp_q        <= lamp_d;
      end
   end

   assign lampPWM    = lamp_q;
   assign blinkPhase = blink_phase_q;

endmodule

// File: tb/tb_lamp_pwm_controller.sv
// Bench for lamp_pwm_controller: ramp vector table, flash/blink/reset sequences,
// with lamp and blink-phase expectations queued ahead and popped each cycle.
`timescale 1ns/1ps

module tb_lamp_pwm_controller;

   localparam int CH = 2;
   localparam int PB = 4;
   localparam int PD = 1;
   localparam int DL = 3;
   localparam int RS = 4;
   localparam int BH = 64;
   localparam int FH = 40;
   localparam int FC = 3;
   localparam int DMAX = 15;
   localparam int NEVER = 1_000_000;

   logic          c50M = 1'b0;
   logic          reset = 1'b1;
   logic [CH-1:0] onReq = '0;
   logic [CH-1:0] dimReq = '0;
   logic [CH-1:0] blinkReq = '0;
   logic [CH-1:0] flashEn = '0;
   logic [CH-1:0] lampPWM;
   logic          blinkPhase;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [1:0] lampQ[$];
   logic       phaseQ[$];

   typedef struct packed {
      logic [1:0] on;
      logic [1:0] dim;
      logic [1:0] fe;
      logic [3:0] d0;
      logic [3:0] d1;
   } vec_t;

   vec_t vecs[14];

   lamp_pwm_controller #(
      .CHANNELS(CH), .PWM_BITS(PB), .PWM_DIV(PD), .DIM_LEVEL(DL), .RAMP_STEP(RS),
      .BLINK_HALF(BH), .FLASH_HALF(FH), .FLASH_COUNT(FC)
   ) dut (
      .c50M(c50M),
      .reset(reset),
      .onReq(onReq),
      .dimReq(dimReq),
      .blinkReq(blinkReq),
      .flashEn(flashEn),
      .lampPWM(lampPWM),
      .blinkPhase(blinkPhase)
   );

   always #5 c50M = ~c50M;

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] on, input logic [1:0] dim,
                                input logic [1:0] blink, input logic [1:0] fe);
      onReq    = on;
      dimReq   = dim;
      blinkReq = blink;
      flashEn  = fe;
   endtask

   // One clock; the queued lamp/phase expectation for this cycle is consumed here.
   task automatic tick();
      logic [1:0] e;
      logic       p;
      @(posedge c50M);
      #1;
      cyc++;
      if (lampQ.size() > 0) begin
         e = lampQ.pop_front();
         checkOutput("lampPWM", int'(lampPWM), int'(e));
      end
      if (phaseQ.size() > 0) begin
         p = phaseQ.pop_front();
         checkOutput("blinkPhase", int'(blinkPhase), int'(p));
      end
   endtask

   task automatic doReset();
      applyStimulus(2'b00, 2'b00, 2'b00, 2'b00);
      reset = 1'b1;
      lampQ.delete();
      phaseQ.delete();
      @(posedge c50M);
      #1;
      reset = 1'b0;
      cyc = 0;
   endtask

   function automatic int lampExp(input int cnt, input int d);
      if (d == 0) return 0;
      if (d == DMAX) return 1;
      return (cnt < d) ? 1 : 0;
   endfunction

   function automatic int stepToward(input int cur, input int tgt);
      if (tgt > cur) return (tgt - cur > RS) ? cur + RS : tgt;
      return (cur - tgt > RS) ? cur - RS : tgt;
   endfunction

   // Expected flash FSM state t cycles after the rising edge was sampled: 0 idle, 1 on, 2 off, 3 steady.
   function automatic int fsmAt(input int t, input int dropT);
      if (t < 0 || t >= dropT) return 0;
      if (t < 2 * FH * FC) return ((t / FH) % 2 == 0) ? 1 : 2;
      return 3;
   endfunction

   function automatic int phaseAt(input int j);
      if (j < 0) return 1;
      return (((j + 1) / BH) % 2 == 0) ? 1 : 0;
   endfunction

   // Channel 0 flash burst; rising edge sampled at cycle 15 so wraps land on t = 0, 16, 32 ...
   task automatic runFlash(input string tag, input int dim0, input int dropT,
                           input int bs, input int be, input int nWraps);
      int md;
      int t;
      int st;
      int wraps;
      bit blinkOn;
      doReset();
      applyStimulus(2'b00, (dim0 != 0) ? 2'b01 : 2'b00, 2'b00, 2'b01);
      md = 0;
      wraps = 0;
      while (cyc < 14) tick();
      onReq = 2'b01;
      while (wraps < nWraps) begin
         tick();
         if (cyc % 16 == 0) begin
            t = cyc - 16;
            st = fsmAt(t, dropT);
            blinkOn = (t + 1 >= bs) && (t + 1 < be);
            if (blinkOn)      md = (phaseAt(t - bs) != 0) ? DMAX : 0;
            else if (st == 1) md = DMAX;
            else if (st == 2) md = 0;
            else if (st == 3) md = stepToward(md, DMAX);
            else              md = stepToward(md, (dim0 != 0) ? DL : 0);
            checkOutput($sformatf("%s duty0 t=%0d", tag, t), int'(dut.duty_q[0]), md);
            wraps++;
         end
         if (cyc == 14 + dropT) onReq = 2'b00;
         if (cyc == 14 + bs)    blinkReq = 2'b01;
         if (cyc == 14 + be)    blinkReq = 2'b00;
      end
   endtask

   initial begin
      int prev0;
      int prev1;
      logic [1:0] e;

      vecs[0]  = '{2'b00, 2'b01, 2'b00, 4'd3,  4'd0};
      vecs[1]  = '{2'b00, 2'b01, 2'b00, 4'd3,  4'd0};
      vecs[2]  = '{2'b01, 2'b01, 2'b00, 4'd7,  4'd0};
      vecs[3]  = '{2'b01, 2'b01, 2'b00, 4'd11, 4'd0};
      vecs[4]  = '{2'b01, 2'b01, 2'b00, 4'd15, 4'd0};
      vecs[5]  = '{2'b01, 2'b01, 2'b00, 4'd15, 4'd0};
      vecs[6]  = '{2'b00, 2'b01, 2'b00, 4'd11, 4'd0};
      vecs[7]  = '{2'b00, 2'b01, 2'b00, 4'd7,  4'd0};
      vecs[8]  = '{2'b00, 2'b01, 2'b00, 4'd3,  4'd0};
      vecs[9]  = '{2'b00, 2'b01, 2'b00, 4'd3,  4'd0};
      vecs[10] = '{2'b00, 2'b10, 2'b00, 4'd0,  4'd3};
      vecs[11] = '{2'b10, 2'b11, 2'b00, 4'd3,  4'd7};
      vecs[12] = '{2'b10, 2'b11, 2'b10, 4'd3,  4'd11};
      vecs[13] = '{2'b00, 2'b00, 2'b00, 4'd0,  4'd7};

      $display("[TB] start");
      doReset();
      checkOutput("reset lampPWM", int'(lampPWM), 0);
      checkOutput("reset blinkPhase", int'(blinkPhase), 1);
      checkOutput("reset duty0", int'(dut.duty_q[0]), 0);
      checkOutput("reset duty1", int'(dut.duty_q[1]), 0);
      checkOutput("reset pwmCount", int'(dut.pwm_count_q), 0);

      // Each vector spans one PWM period; lamp pattern comes from the previous duties.
      prev0 = 0;
      prev1 = 0;
      for (int i = 0; i < 14; i++) begin
         applyStimulus(vecs[i].on, vecs[i].dim, 2'b00, vecs[i].fe);
         for (int k = 0; k < 16; k++) begin
            e = {lampExp(k, prev1) != 0, lampExp(k, prev0) != 0};
            lampQ.push_back(e);
         end
         repeat (16) tick();
         checkOutput($sformatf("vec%0d duty0", i), int'(dut.duty_q[0]), int'(vecs[i].d0));
         checkOutput($sformatf("vec%0d duty1", i), int'(dut.duty_q[1]), int'(vecs[i].d1));
         prev0 = int'(vecs[i].d0);
         prev1 = int'(vecs[i].d1);
      end

      runFlash("flash", 0, NEVER, NEVER, NEVER, 20);
      runFlash("abort", 1, 64, NEVER, NEVER, 8);
      runFlash("blinkflash", 0, NEVER, 16, 274, 20);

      // Blink on channel 1, released while the phase is dark.
      doReset();
      applyStimulus(2'b00, 2'b00, 2'b10, 2'b00);
      for (int c = 1; c <= 200; c++) phaseQ.push_back(phaseAt(c - 1) != 0);
      while (cyc < 200) begin
         tick();
         if (cyc % 16 == 0) begin
            checkOutput($sformatf("blink duty1 c=%0d", cyc), int'(dut.duty_q[1]),
                        (phaseAt(cyc - 2) != 0) ? DMAX : 0);
            checkOutput($sformatf("blink duty0 c=%0d", cyc), int'(dut.duty_q[0]), 0);
         end
      end
      blinkReq = 2'b00;
      tick();
      checkOutput("blink release phase", int'(blinkPhase), 1);
      checkOutput("blink release counter", int'(dut.blink_cnt_q), 0);
      while (cyc < 208) tick();
      checkOutput("blink release duty1 ramp", int'(dut.duty_q[1]), 11);

      // Asynchronous reset in the middle of a ramp while blink phase is dark.
      doReset();
      applyStimulus(2'b00, 2'b00, 2'b10, 2'b00);
      while (cyc < 48) tick();
      onReq = 2'b01;
      while (cyc < 82) tick();
      checkOutput("pre-reset duty0", int'(dut.duty_q[0]), 8);
      checkOutput("pre-reset lamp0", int'(lampPWM[0]), 1);
      checkOutput("pre-reset blinkPhase", int'(blinkPhase), 0);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("async reset lampPWM", int'(lampPWM), 0);
      checkOutput("async reset blinkPhase", int'(blinkPhase), 1);
      checkOutput("async reset duty0", int'(dut.duty_q[0]), 0);
      checkOutput("async reset duty1", int'(dut.duty_q[1]), 0);
      @(posedge c50M);
      #1;
      reset = 1'b0;
      cyc = 0;
      for (int k = 0; k < 16; k++) lampQ.push_back(2'b00);
      repeat (16) tick();
      checkOutput("post-reset duty0", int'(dut.duty_q[0]), 4);
      checkOutput("post-reset duty1", int'(dut.duty_q[1]), DMAX);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
